vec_regfile_masked: RTL
=======================

Name: vec_regfile_masked

Overview:
Parametrised vector register file for the vector datapath. Generalised in register count, vector width, element width and read-port count. Adds:
- per-lane write masks with a fixed write-port priority,
- registered read ports,
- a busy scoreboard for reserve/write-back handshakes with the issue stage.

It sits between the issue/decode stage (reads, reservations) and the execution/memory write-back paths (two write ports).

Parameters:
NREG, 4, number of vector registers (power of 2, >=2)
VLEN, 512, bits per vector register
ELEN, 32, bits per element lane; VLEN % ELEN == 0
NRD, 2, number of read ports
Derived: LANES = VLEN/ELEN; AW = clog2(NREG)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
we1  in  1  write port 1 enable
wr_reg1  in  AW  write port 1 register index
wr_data1  in  VLEN  write port 1 data
wr_mask1  in  LANES  write port 1 lane enables (bit i -> bits [i*ELEN +: ELEN])
we2  in  1  write port 2 enable
wr_reg2  in  AW  write port 2 register index
wr_data2  in  VLEN  write port 2 data
wr_mask2  in  LANES  write port 2 lane enables
rd_en  in  NRD  per-port read strobe
rd_reg  in  NRD*AW  read indices, port p at [p*AW +: AW]
rd_data  out  NRD*VLEN  registered read data, port p at [p*VLEN +: VLEN]
rd_valid  out  NRD  rd_data for port p valid this cycle
rsv_en  in  1  reservation request (issue marks destination pending)
rsv_reg  in  AW  register to reserve
rsv_ok  out  1  combinational: rsv_en && !busy[rsv_reg]
busy  out  NREG  scoreboard, bit r = write pending on register r
regs_flat  out  NREG*VLEN  direct view of all registers, register r at [r*VLEN +: VLEN]

Behaviour:
- Reset (rst_n low, async):
  - all registers = 0; busy = 0; rd_data = 0; rd_valid = 0.
  - Effect is immediate and holds while low. Any write or reservation in flight is dropped.
- Writes, 1-cycle commit:
  - On the edge with weK=1, each lane i of register wr_regK with wr_maskK[i]=1 takes wr_dataK lane i.
  - Unmasked lanes keep their value.
  - Mask all-zero with weK=1: no data change, but the busy clear still applies.
- Write conflict: we1 && we2 && wr_reg1==wr_reg2:
  - lanes enabled in both masks take port 2 data;
  - lanes enabled in only one mask take that port's data.
- Writes to different registers are fully independent.
- Reads:
  - rd_en[p] at edge t -> rd_data[p] = register rd_reg[p] contents as they were before edge t's writes (read-before-write); rd_valid[p]=1 after edge t.
  - rd_en[p]=0 -> rd_valid[p]=0 next cycle; rd_data[p] holds its last value.
  - Any number of ports may read the same register in the same cycle.
- regs_flat: reflects committed register state (post-edge), no extra latency.
- Scoreboard:
  - rsv_en && !busy[rsv_reg] -> busy[rsv_reg] set at the edge.
  - rsv_en on an already-busy register -> ignored; rsv_ok=0; issue must stall.
  - weK at an edge clears busy[wr_regK], regardless of mask.
  - Reservation and write to the same register at the same edge: reservation wins, busy ends 1 (new producer issued as the old one retires).
  - Writes to a non-busy register are legal and leave busy at 0.
- Indices are AW bits wide, so no out-of-range case exists.

Optional Feature:
Macro VRF_BYPASS_EN.
- Defined: a read sampled at edge t returns write-forwarded data. Per lane, the value written at edge t (with port 2 priority) if the lane is enabled on a write to the same register, else the stored value. Read-after-write in the same cycle therefore costs no stall.
- Undefined: read-before-write as above.
- Scoreboard and write semantics are identical in both builds.

Test Plan:
- Reset: drive writes and reservations, pull rst_n low mid-cycle -> regs_flat, busy, rd_valid read 0 immediately, without waiting for a clock edge.
- Masked write (defaults): reg 1 = all 0x11111111, then we1 with wr_reg1=1, wr_data1 all 0xAAAAAAAA, wr_mask1=16'h00FF -> lanes 0-7 = 0xAAAAAAAA, lanes 8-15 = 0x11111111.
- Port conflict: we1 and we2 both to reg 2, data 0x1.../0x2..., masks 16'h0F0F / 16'h00FF -> lanes 0-3 = 0x2..., lanes 4-7 = 0x2..., lanes 8-11 = 0x1..., lanes 12-15 unchanged.
- Read timing: reg 3 = X, then at the same edge write reg 3 = Y and rd_en[0] with rd_reg=3:
  - bypass off -> rd_data[0] = X, rd_valid[0] = 1 next cycle;
  - bypass on -> rd_data[0] = Y.
  Reading reg 3 on both ports in the same cycle -> identical rd_data.
- Scoreboard:
  - rsv_en reg 0 -> busy=4'b0001;
  - rsv_en reg 0 again -> rsv_ok=0, busy unchanged;
  - we2 reg 0 with mask 0 -> busy=0, data unchanged;
  - simultaneous rsv reg 1 and we1 reg 1 -> busy[1] stays 1.
- Parameter sweep: NREG=8, VLEN=128, ELEN=16, NRD=3 -> random writes/reads checked against a reference model over 1000 cycles, zero mismatches.

Source files
------------

// File: rtl/vec_regfile_masked.sv
// vec_regfile_masked: NREG x VLEN vector register file with per-lane write
// masks, two write ports, NRD registered read ports and a busy scoreboard
// for reserve / write-back handshakes with the issue stage.
//
// Optional build macro: VRF_BYPASS_EN
//   undefined : reads return register contents from before the same-edge writes
//   defined   : reads return the same-edge written data, merged per lane
//
// When both write ports hit the same register, port 2 owns every lane that
// both masks enable. Lanes enabled by only one port take that port's data.
`timescale 1ns/1ps

module vec_regfile_masked #(
  parameter  int NREG  = 4,
  parameter  int VLEN  = 512,
  parameter  int ELEN  = 32,
  parameter  int NRD   = 2,
  localparam int LANES = VLEN / ELEN,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we1,
  input  logic [AW-1:0]        wr_reg1,
  input  logic [VLEN-1:0]      wr_data1,
  input  logic [LANES-1:0]     wr_mask1,
  input  logic                 we2,
  input  logic [AW-1:0]        wr_reg2,
  input  logic [VLEN-1:0]      wr_data2,
  input  logic [LANES-1:0]     wr_mask2,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_reg,
  output logic [NRD*VLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_valid,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_reg,
  output logic                 rsv_ok,
  output logic [NREG-1:0]      busy,
  output logic [NREG*VLEN-1:0] regs_flat
);

  logic [VLEN-1:0]     r_regs     [NREG];
  logic [VLEN-1:0]     w_regs_nxt [NREG];
  logic [VLEN-1:0]     w_rd_src   [NREG];
  logic [NREG-1:0]     r_busy;
  logic [NREG-1:0]     w_busy_clr;
  logic [NREG-1:0]     w_busy_set;
  logic [NRD*VLEN-1:0] r_rd_data;
  logic [NRD-1:0]      r_rd_valid;

  genvar gr, gl;
  generate
    for (gr = 0; gr < NREG; gr++) begin : g_reg
      logic            w_wr1;
      logic            w_wr2;
      logic [VLEN-1:0] w_nxt;

      assign w_wr1 = we1 && (wr_reg1 == AW'(gr));
      assign w_wr2 = we2 && (wr_reg2 == AW'(gr));

      for (gl = 0; gl < LANES; gl++) begin : g_lane
        assign w_nxt[gl*ELEN +: ELEN] =
          (w_wr2 && wr_mask2[gl]) ? wr_data2[gl*ELEN +: ELEN] :
          (w_wr1 && wr_mask1[gl]) ? wr_data1[gl*ELEN +: ELEN] :
                                    r_regs[gr][gl*ELEN +: ELEN];
      end

      assign w_regs_nxt[gr]              = w_nxt;
      // Any write retires the pending producer, even with an all-zero mask.
      assign w_busy_clr[gr]              = w_wr1 | w_wr2;
      assign regs_flat[gr*VLEN +: VLEN]  = r_regs[gr];
    end
  endgenerate

  // A reservation is only granted on a free register; the issue stage stalls otherwise.
  assign rsv_ok     = rsv_en && !r_busy[rsv_reg];
  assign w_busy_set = rsv_ok ? (NREG'(1) << rsv_reg) : '0;

`ifdef VRF_BYPASS_EN
  assign w_rd_src = w_regs_nxt;
`else
  assign w_rd_src = r_regs;
`endif

  // Register array commit: every register loads its lane-merged next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= w_regs_nxt[r];
    end
  end

  // Scoreboard: clear on write-back, then set on grant so a same-edge reservation wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
  end

  // Registered read ports; data holds when a port is not strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        r_rd_valid[p] <= rd_en[p];
        if (rd_en[p]) r_rd_data[p*VLEN +: VLEN] <= w_rd_src[rd_reg[p*AW +: AW]];
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign busy     = r_busy;

endmodule
